// File: rtl/layer2_result_reader_pkg.sv
// ---------------------------------------------------------------------------
// layer2_pkg
// Shared constants and types for the layer-2 result reader slice.
//   L2_ROWS / L2_COLS : default stored map extents (30 x 30)
//   L2_DATA_W         : default result word width, tied to LAYER2_OUTPUT_LENGTH
//   L2_ADDR_W         : width of the row/column address and coordinate tags
//   reader_state_t    : reader FSM state encoding
// ---------------------------------------------------------------------------
`ifndef LAYER2_OUTPUT_LENGTH
`define LAYER2_OUTPUT_LENGTH 128
`endif

package layer2_pkg;

  localparam int unsigned L2_ROWS   = 30;
  localparam int unsigned L2_COLS   = 30;
  localparam int unsigned L2_DATA_W = `LAYER2_OUTPUT_LENGTH;
  localparam int unsigned L2_ADDR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } reader_state_t;

endpackage

// File: rtl/layer2_result_reader_coord_cnt.sv
// ---------------------------------------------------------------------------
// layer2_reader_coord_cnt
// Raster row/column counter (column fastest) with clear, advance and wrap.
// Besides the current coordinate it exposes the coordinate that an advance
// would produce, so the reader can address the next word in the same cycle
// the current beat is accepted.
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   clr_i          : return to (0,0) (priority over adv_i)
//   adv_i          : step to the next raster coordinate
//   row_o, col_o   : current coordinate;  last_o : current is final position
//   nxt_row_o/col_o: coordinate after an advance; nxt_last_o : it is final
// ---------------------------------------------------------------------------
module layer2_reader_coord_cnt
  import layer2_pkg::*;
#(
  parameter int unsigned ROWS = L2_ROWS,
  parameter int unsigned COLS = L2_COLS,
  parameter int unsigned W    = L2_ADDR_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         adv_i,
  output logic [W-1:0] row_o,
  output logic [W-1:0] col_o,
  output logic         last_o,
  output logic [W-1:0] nxt_row_o,
  output logic [W-1:0] nxt_col_o,
  output logic         nxt_last_o
);

  localparam logic [W-1:0] ROW_MAX = W'(ROWS - 1);
  localparam logic [W-1:0] COL_MAX = W'(COLS - 1);

  logic [W-1:0] row_q, row_d;
  logic [W-1:0] col_q, col_d;
  logic [W-1:0] nxt_row, nxt_col;

  always_comb begin
    nxt_row = row_q;
    nxt_col = col_q + W'(1);
    if (col_q == COL_MAX) begin
      nxt_col = '0;
      nxt_row = (row_q == ROW_MAX) ? '0 : row_q + W'(1);
    end
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (adv_i) begin
      row_d = nxt_row;
      col_d = nxt_col;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o      = row_q;
  assign col_o      = col_q;
  assign last_o     = (row_q == ROW_MAX) && (col_q == COL_MAX);
  assign nxt_row_o  = nxt_row;
  assign nxt_col_o  = nxt_col;
  assign nxt_last_o = (nxt_row == ROW_MAX) && (nxt_col == COL_MAX);

endmodule

// File: rtl/layer2_result_reader.sv
// ---------------------------------------------------------------------------
// layer2_result_reader
// Scans the layer-2 result memory in raster order on a start pulse and
// streams each word downstream over valid/ready with row/col/last tags,
// one beat per cycle when the consumer does not stall.
//
// Ports:
//   clk, rst (sync, active-low)      start  : scan request (IDLE only)
//   busy, done                        : frame in progress / end-of-frame pulse
//   read_row_addr, read_col_addr      : memory address (0 when strobe low)
//   layer2_result_read_signal         : memory read strobe
//   layer2_result_output              : memory data, same-cycle as strobe
//   out_data, out_row, out_col,
//   out_last, out_valid, out_ready    : downstream stream
//
// Build option: define LAYER2_READER_PAD_EN to emit a one-pixel zero border,
// scanning (ROWS+2)x(COLS+2); border beats carry zero and never strobe memory.
// ---------------------------------------------------------------------------
module layer2_result_reader
  import layer2_pkg::*;
#(
  parameter int unsigned ROWS   = L2_ROWS,
  parameter int unsigned COLS   = L2_COLS,
  parameter int unsigned DATA_W = L2_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [L2_ADDR_W-1:0] read_row_addr,
  output logic [L2_ADDR_W-1:0] read_col_addr,
  output logic                 layer2_result_read_signal,
  input  logic [DATA_W-1:0]    layer2_result_output,
  output logic [DATA_W-1:0]    out_data,
  output logic [L2_ADDR_W-1:0] out_row,
  output logic [L2_ADDR_W-1:0] out_col,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready
);

`ifdef LAYER2_READER_PAD_EN
  localparam int unsigned SCAN_ROWS = ROWS + 2;
  localparam int unsigned SCAN_COLS = COLS + 2;
`else
  localparam int unsigned SCAN_ROWS = ROWS;
  localparam int unsigned SCAN_COLS = COLS;
`endif

  reader_state_t state_q, state_d;

  logic                 cnt_clr, cnt_adv;
  logic                 capture, use_nxt;
  logic [L2_ADDR_W-1:0] cur_row, cur_col, nxt_row, nxt_col;
  logic                 cur_last, nxt_last;

  logic [L2_ADDR_W-1:0] fetch_row, fetch_col;
  logic                 fetch_last;
  logic                 interior;
  logic [L2_ADDR_W-1:0] mem_row, mem_col;
  logic                 rd_strobe;

  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic [L2_ADDR_W-1:0] out_row_q, out_row_d;
  logic [L2_ADDR_W-1:0] out_col_q, out_col_d;
  logic                 out_last_q, out_last_d;

  layer2_reader_coord_cnt #(
    .ROWS (SCAN_ROWS),
    .COLS (SCAN_COLS),
    .W    (L2_ADDR_W)
  ) u_coord_cnt (
    .clk_i      (clk),
    .rst_ni     (rst),
    .clr_i      (cnt_clr),
    .adv_i      (cnt_adv),
    .row_o      (cur_row),
    .col_o      (cur_col),
    .last_o     (cur_last),
    .nxt_row_o  (nxt_row),
    .nxt_col_o  (nxt_col),
    .nxt_last_o (nxt_last)
  );

  // capture is exactly the strobe condition of the unpadded scan:
  // FETCH, or SEND with a handshake on a non-final beat.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_adv = 1'b0;
    capture = 1'b0;
    use_nxt = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_clr = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        capture = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d = ST_DONE;
          end else begin
            cnt_adv = 1'b1;
            capture = 1'b1;
            use_nxt = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // In FETCH the counter already holds (0,0); in SEND it holds the beat on
  // the bus, so the word being read belongs to the following coordinate.
  assign fetch_row  = use_nxt ? nxt_row  : cur_row;
  assign fetch_col  = use_nxt ? nxt_col  : cur_col;
  assign fetch_last = use_nxt ? nxt_last : cur_last;

`ifdef LAYER2_READER_PAD_EN
  assign interior = (fetch_row != '0) && (fetch_row <= L2_ADDR_W'(ROWS)) &&
                    (fetch_col != '0) && (fetch_col <= L2_ADDR_W'(COLS));
  assign mem_row  = fetch_row - L2_ADDR_W'(1);
  assign mem_col  = fetch_col - L2_ADDR_W'(1);
`else
  assign interior = 1'b1;
  assign mem_row  = fetch_row;
  assign mem_col  = fetch_col;
`endif

  assign rd_strobe = capture & interior;

  always_comb begin
    out_data_d = out_data_q;
    out_row_d  = out_row_q;
    out_col_d  = out_col_q;
    out_last_d = out_last_q;
    if (capture) begin
      out_data_d = interior ? layer2_result_output : '0;
      out_row_d  = fetch_row;
      out_col_d  = fetch_col;
      out_last_d = fetch_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      out_data_q <= '0;
      out_row_q  <= '0;
      out_col_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_row_q  <= out_row_d;
      out_col_q  <= out_col_d;
      out_last_q <= out_last_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign out_valid = (state_q == ST_SEND);
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;

  assign layer2_result_read_signal = rd_strobe;
  assign read_row_addr             = rd_strobe ? mem_row : '0;
  assign read_col_addr             = rd_strobe ? mem_col : '0;

endmodule

// File: tb/tb_layer2_result_reader.sv
module tb_layer2_result_reader;
  import layer2_pkg::*;

  localparam int ROWS = 30;
  localparam int COLS = 30;
  localparam int DW   = L2_DATA_W;
`ifdef LAYER2_READER_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif
  localparam int SR = ROWS + 2 * PAD;
  localparam int SC = COLS + 2 * PAD;
  localparam int N  = SR * SC;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, done, strobe, out_last, out_valid;
  logic [15:0]   rd_row, rd_col, out_row, out_col;
  logic [DW-1:0] rd_data, out_data;

  logic [DW-1:0] mem [ROWS][COLS];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Combinational memory: returns the stored word while strobed at a legal
  // address, otherwise an all-ones junk word so stray captures stand out.
  always_comb begin
    rd_data = {DW{1'b1}};
    if (strobe && int'(rd_row) < ROWS && int'(rd_col) < COLS)
      rd_data = mem[int'(rd_row)][int'(rd_col)];
  end

  layer2_result_reader dut (
    .clk                       (clk),
    .rst                       (rst),
    .start                     (start),
    .busy                      (busy),
    .done                      (done),
    .read_row_addr             (rd_row),
    .read_col_addr             (rd_col),
    .layer2_result_read_signal (strobe),
    .layer2_result_output      (rd_data),
    .out_data                  (out_data),
    .out_row                   (out_row),
    .out_col                   (out_col),
    .out_last                  (out_last),
    .out_valid                 (out_valid),
    .out_ready                 (out_ready)
  );

  function automatic bit interior(input int r, input int c);
    return (r >= PAD) && (r < ROWS + PAD) && (c >= PAD) && (c < COLS + PAD);
  endfunction

  function automatic logic [DW-1:0] exp_word(input int r, input int c);
    if (!interior(r, c)) return '0;
    return mem[r - PAD][c - PAD];
  endfunction

  // Runs one frame starting from IDLE, caller positioned just after a falling
  // edge. stall_beat/stall_len: hold ready low on that beat; rand_ready:
  // random backpressure; poke_beat: pulse start while that beat is on the bus.
  task automatic run_scan(input string tag, input int stall_beat, input int stall_len,
                          input bit rand_ready, input int poke_beat);
    int beat = 0, stalled = 0, burst = 0, cyc = 1;
    int er, ec, fr, fc;
    bit poked = 0, finished = 0, rdy, ev, has_fetch, exp_strb;
    logic [DW-1:0] ew;
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!finished && cyc < 4 * N + 100) begin
      ev  = (cyc >= 2) && (beat < N);
      rdy = 1'b1;
      if (ev) begin
        if (rand_ready) rdy = ($urandom_range(0, 3) != 0);
        else if (beat == stall_beat && burst < stall_len) begin
          rdy = 1'b0;
          burst++;
        end
      end
      out_ready = rdy;
      start = ev && (beat == poke_beat) && !poked;
      if (start) poked = 1'b1;
      #1;
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++; $display("FAIL %s busy: got %b expected 1 (cycle %0d)", tag, busy, cyc);
      end
      n_checks++;
      if (out_valid !== ev) begin
        n_fail++; $display("FAIL %s out_valid: got %b expected %b (cycle %0d)", tag, out_valid, ev, cyc);
      end
      n_checks++;
      if (done !== (beat == N)) begin
        n_fail++; $display("FAIL %s done: got %b expected %b (cycle %0d)", tag, done, beat == N, cyc);
      end
      if (ev) begin
        er = beat / SC;
        ec = beat % SC;
        ew = exp_word(er, ec);
        n_checks++;
        if (out_row !== 16'(er) || out_col !== 16'(ec)) begin
          n_fail++; $display("FAIL %s coord: got (%0d,%0d) expected (%0d,%0d)", tag, out_row, out_col, er, ec);
        end
        n_checks++;
        if (out_last !== (beat == N - 1)) begin
          n_fail++; $display("FAIL %s out_last: got %b expected %b at (%0d,%0d)", tag, out_last, beat == N - 1, er, ec);
        end
        n_checks++;
        if (out_data !== ew) begin
          n_fail++; $display("FAIL %s data at (%0d,%0d): got %h expected %h", tag, er, ec, out_data, ew);
        end
      end
      has_fetch = 1'b0;
      fr = 0;
      fc = 0;
      if (cyc == 1) has_fetch = 1'b1;
      else if (ev && rdy && beat + 1 < N) begin
        has_fetch = 1'b1;
        fr = (beat + 1) / SC;
        fc = (beat + 1) % SC;
      end
      exp_strb = has_fetch && interior(fr, fc);
      n_checks++;
      if (strobe !== exp_strb) begin
        n_fail++; $display("FAIL %s strobe: got %b expected %b (cycle %0d beat %0d)", tag, strobe, exp_strb, cyc, beat);
      end
      n_checks++;
      if (rd_row !== (exp_strb ? 16'(fr - PAD) : 16'd0) || rd_col !== (exp_strb ? 16'(fc - PAD) : 16'd0)) begin
        n_fail++; $display("FAIL %s addr: got (%0d,%0d) expected strobe=%b scan (%0d,%0d) (cycle %0d)", tag, rd_row, rd_col, exp_strb, fr, fc, cyc);
      end
      if (beat == N) begin
        n_checks++;
        if (cyc != N + stalled + 2) begin
          n_fail++; $display("FAIL %s done_cycle: got %0d expected %0d", tag, cyc, N + stalled + 2);
        end
        finished = 1'b1;
      end else begin
        if (ev && rdy) beat++;
        if (ev && !rdy) stalled++;
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (!finished) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: got %0d beats expected %0d", tag, beat, N);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s post_done: got busy=%b done=%b valid=%b expected 0", tag, busy, done, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({busy, done, strobe, out_valid, out_last} !== 5'b0) begin
      n_fail++; $display("FAIL reset flags: got %b expected 00000", {busy, done, strobe, out_valid, out_last});
    end
    n_checks++;
    if (out_data !== '0 || out_row !== 16'd0 || out_col !== 16'd0 || rd_row !== 16'd0 || rd_col !== 16'd0) begin
      n_fail++; $display("FAIL reset values: got data=%h row=%0d col=%0d addr=(%0d,%0d) expected 0", out_data, out_row, out_col, rd_row, rd_col);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || strobe !== 1'b0) begin
      n_fail++; $display("FAIL idle_quiet: got busy=%b strobe=%b expected 0", busy, strobe);
    end
  endtask

  task automatic test_no_stall();
    run_scan("no_stall", -1, 0, 1'b0, -1);
  endtask

  task automatic test_stall();
    run_scan("stall", 5, 3, 1'b0, -1);
  endtask

  task automatic test_start_while_busy();
    run_scan("start_busy", -1, 0, 1'b0, 50);
  endtask

  task automatic test_reset_midframe();
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (101) @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_row !== 16'(100 / SC) || out_col !== 16'(100 % SC)) begin
      n_fail++; $display("FAIL midframe beat100: got valid=%b (%0d,%0d) expected 1 (%0d,%0d)", out_valid, out_row, out_col, 100 / SC, 100 % SC);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if ({busy, done, strobe, out_valid, out_last} !== 5'b0) begin
      n_fail++; $display("FAIL midframe reset flags: got %b expected 00000", {busy, done, strobe, out_valid, out_last});
    end
    n_checks++;
    if (out_data !== '0 || out_row !== 16'd0 || out_col !== 16'd0 || rd_row !== 16'd0 || rd_col !== 16'd0) begin
      n_fail++; $display("FAIL midframe reset values: got data=%h row=%0d col=%0d addr=(%0d,%0d) expected 0", out_data, out_row, out_col, rd_row, rd_col);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL midframe no_done: got done=%b busy=%b expected 0", done, busy);
      end
    end
    run_scan("after_reset", -1, 0, 1'b0, -1);
  endtask

  task automatic test_random_stalls();
    run_scan("rand_ready", -1, 0, 1'b1, -1);
  endtask

  task automatic test_back_to_back();
    run_scan("b2b_first", -1, 0, 1'b0, -1);
    run_scan("b2b_second", 17, 2, 1'b0, -1);
  endtask

  initial begin
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mem[r][c] = DW'({$urandom, $urandom, $urandom, 32'(r * 30 + c)});
    test_reset();
    test_no_stall();
    test_stall();
    test_start_while_busy();
    test_reset_midframe();
    test_random_stalls();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
